// File: rtl/sync_merge_pkg.sv
// Shared types and the round-robin picker for the N-channel synchronising merge.
// The picker works on a fixed maximum width; callers pass their channel count.
package sync_merge_pkg;

    localparam int unsigned MAX_CH = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_e;

    // One-hot winner: first set request scanning ptr, ptr+1, ... wrapping at n_ch.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [3:0]        ptr,
        input int unsigned       n_ch
    );
        logic [MAX_CH-1:0] win;
        logic              found;
        int unsigned       idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n_ch) begin
                idx = idx - n_ch;
            end
            if ((i < n_ch) && !found && (idx < MAX_CH) && req[idx[3:0]]) begin
                win[idx[3:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sync_nstage.sv
// Multi-flop synchroniser chain for a bus of independent asynchronous bits.
module sync_nstage #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stg_q;
    logic [STAGES-1:0][W-1:0] stg_d;

    always_comb begin
        stg_d    = stg_q;
        stg_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/sync_merge_n.sv
// N-channel four-phase merge: synchronises requesters, arbitrates round-robin and
// forwards the granted data word over one registered four-phase output channel.
module sync_merge_n
    import sync_merge_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_CH-1:0]    req_i,
    input  logic [N_CH*DW-1:0] data_i,
    output logic [N_CH-1:0]    ack_o,
    output logic               req_o,
    output logic [DW-1:0]      data_o,
    input  logic               ack_i,
    output logic [N_CH-1:0]    grant_o,
    output logic               busy_o
);

    localparam int unsigned PW = $clog2(N_CH);

    logic [N_CH-1:0] req_s;
    logic [0:0]      ack_s;

    sync_nstage #(.W(N_CH), .STAGES(SYNC_STAGES)) u_sync_req (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (req_i),
        .q       (req_s)
    );

    sync_nstage #(.W(1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ack_i),
        .q       (ack_s)
    );

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            req_o_q, req_o_d;
    logic [N_CH-1:0] ack_o_q, ack_o_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic            busy_q, busy_d;

    logic [MAX_CH-1:0] req_pad;
    logic [N_CH-1:0]   win_oh;
    logic [DW-1:0]     win_data;
    logic [PW-1:0]     gidx;

    always_comb begin
        req_pad            = '0;
        req_pad[N_CH-1:0]  = req_s;
        win_oh             = N_CH'(rr_pick(req_pad, 4'(ptr_q), N_CH));
        win_data           = '0;
        gidx               = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (win_oh[k]) begin
                win_data = data_i[k*DW +: DW];
            end
            if (grant_q[k]) begin
                gidx = PW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        req_o_d = req_o_q;
        ack_o_d = ack_o_q;
        grant_d = grant_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                // A lingering ack from the previous transaction blocks new grants.
                if ((|req_s) && !ack_s[0]) begin
                    grant_d = win_oh;
                    data_d  = win_data;
                    req_o_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s[0]) begin
                    req_o_d = 1'b0;
                    ack_o_d = grant_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!(|(req_s & grant_q)) && !ack_s[0]) begin
                    ack_o_d = '0;
                    grant_d = '0;
                    ptr_d   = (gidx == PW'(N_CH-1)) ? '0 : gidx + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            req_o_q <= 1'b0;
            ack_o_q <= '0;
            grant_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            req_o_q <= req_o_d;
            ack_o_q <= ack_o_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_o   = ack_o_q;
    assign req_o   = req_o_q;
    assign data_o  = data_q;
    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_sync_merge_n.sv
// Self-checking bench for sync_merge_n: table of single transactions, hand-written
// corner sequences, and a randomized run scored against a round-robin reference.
module tb_sync_merge_n;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  ack_o;
    logic        req_o;
    logic [7:0]  data_o;
    logic        ack_i;
    logic [3:0]  grant_o;
    logic        busy_o;

    sync_merge_n #(.N_CH(4), .DW(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .req_o   (req_o),
        .data_o  (data_o),
        .ack_i   (ack_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_tot  = 0;
    logic [12:0] dly;
    logic       ds_auto;
    logic       rnd_on;
    logic       mdl_on;
    logic       prev_req_o;
    int         ptr_m;
    int         n_grants;
    logic [7:0] dat_m [4];
    logic [3:0] hist [$];

    typedef struct {
        int         ch;
        logic [7:0] d;
        logic [3:0] exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int rr_ref(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (p + i) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock step: sample at the falling edge, then update upstream/downstream models.
    task automatic tick();
        logic [3:0] v;
        int         w;
        logic [7:0] d;
        @(negedge clk);
        chk("one_ack", 32'($countones(ack_o) <= 1), 32'd1);
        chk("ack_in_grant", 32'(ack_o & ~grant_o), 32'd0);
        chk("busy_vs_grant", 32'(busy_o), 32'(grant_o != 4'd0));
        if (mdl_on && req_o && !prev_req_o) begin
            v = (hist.size() >= 3) ? hist[hist.size()-3] : 4'd0;
            w = rr_ref(v, ptr_m);
            chk("rr_grant", 32'(grant_o), (w < 0) ? 32'd0 : (32'd1 << w));
            if (w >= 0) begin
                chk("rr_data", 32'(data_o), 32'(dat_m[w]));
                ptr_m = (w + 1) % 4;
            end
            n_grants++;
        end
        prev_req_o = req_o;
        dly = {dly[11:0], req_o};
        if (ds_auto) ack_i = dly[12];
        for (int k = 0; k < 4; k++) begin
            if (req_i[k] && ack_o[k]) begin
                req_i[k] = 1'b0;
            end else if (rnd_on && !req_i[k] && !ack_o[k] && ($urandom_range(0, 7) == 0)) begin
                d = 8'($urandom_range(0, 255));
                data_i[k*8 +: 8] = d;
                dat_m[k] = d;
                req_i[k] = 1'b1;
            end
        end
        hist.push_back(req_i);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_i   = '0;
        data_i  = '0;
        dly     = '0;
        ack_i   = 1'b0;
        ds_auto = 1'b1;
        repeat (3) tick();
        chk("rst_req_o", 32'(req_o), 32'd0);
        chk("rst_ack_o", 32'(ack_o), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_grant_o", 32'(grant_o), 32'd0);
        chk("rst_busy_o", 32'(busy_o), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_req_o(input logic v, input string nm, output int n);
        n = 0;
        while (req_o !== v && n < 200) begin
            tick();
            n++;
        end
        if (req_o !== v) chk({nm, "_timeout"}, 32'(req_o), 32'(v));
    endtask

    task automatic wait_ack(input int ch, input logic v, input string nm, output int n);
        n = 0;
        while (ack_o[ch] !== v && n < 200) begin
            tick();
            n++;
        end
        if (ack_o[ch] !== v) chk({nm, "_timeout"}, 32'(ack_o[ch]), 32'(v));
    endtask

    task automatic run_single(input vec_t t);
        int n;
        req_i[t.ch] = 1'b1;
        data_i[t.ch*8 +: 8] = t.d;
        wait_req_o(1'b1, "single_req", n);
        chk("req_latency", 32'(n), 32'd3);
        chk("single_grant", 32'(grant_o), 32'(t.exp_grant));
        chk("single_data", 32'(data_o), 32'(t.exp_data));
        chk("single_busy", 32'(busy_o), 32'd1);
        n = 0;
        while (ack_i !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        wait_ack(t.ch, 1'b1, "single_ack", n);
        chk("ack_latency", 32'(n), 32'd3);
        chk("ack_req_o_low", 32'(req_o), 32'd0);
        chk("ack_data_held", 32'(data_o), 32'(t.exp_data));
        wait_ack(t.ch, 1'b0, "single_ackfall", n);
        chk("done_grant", 32'(grant_o), 32'd0);
        chk("done_busy", 32'(busy_o), 32'd0);
        n = 0;
        while (ack_i !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rnd_on     = 1'b0;
        mdl_on     = 1'b0;
        prev_req_o = 1'b0;
        ptr_m      = 0;
        n_grants   = 0;
        for (int k = 0; k < 4; k++) dat_m[k] = '0;

        // Ordered so that the round-robin pointer ends at 3 (after channel 2).
        vecs[0] = '{ch: 0, d: 8'h3C, exp_grant: 4'b0001, exp_data: 8'h3C};
        vecs[1] = '{ch: 3, d: 8'hFF, exp_grant: 4'b1000, exp_data: 8'hFF};
        vecs[2] = '{ch: 1, d: 8'h5A, exp_grant: 4'b0010, exp_data: 8'h5A};
        vecs[3] = '{ch: 2, d: 8'hA5, exp_grant: 4'b0100, exp_data: 8'hA5};

        do_reset();
        for (int i = 0; i < 4; i++) run_single(vecs[i]);

        // Wrap-around: pointer is 3, so ch3 wins before ch0.
        data_i[0 +: 8]  = 8'h40;
        data_i[24 +: 8] = 8'h43;
        req_i = 4'b1001;
        wait_req_o(1'b1, "wrap1", n);
        chk("wrap_first_grant", 32'(grant_o), 32'h8);
        chk("wrap_first_data", 32'(data_o), 32'h43);
        wait_req_o(1'b0, "wrap1_done", n);
        wait_req_o(1'b1, "wrap2", n);
        chk("wrap_second_grant", 32'(grant_o), 32'h1);
        chk("wrap_second_data", 32'(data_o), 32'h40);
        wait_ack(0, 1'b1, "wrap2_ack", n);
        wait_ack(0, 1'b0, "wrap2_ackfall", n);

        // Simultaneous requests from reset: strict order ch0..ch3.
        do_reset();
        data_i = 32'h13121110;
        req_i  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_req_o(1'b1, "sim_req", n);
            chk("sim_grant", 32'(grant_o), 32'd1 << i);
            chk("sim_data", 32'(data_o), 32'h10 + i);
            wait_ack(i, 1'b1, "sim_ack", n);
            wait_ack(i, 1'b0, "sim_ackfall", n);
        end

        // Late arrival on ch1 while ch0 is in REQ.
        do_reset();
        data_i[0 +: 8] = 8'h20;
        req_i[0] = 1'b1;
        wait_req_o(1'b1, "late_req0", n);
        data_i[8 +: 8] = 8'h21;
        req_i[1] = 1'b1;
        n = 0;
        while (ack_o[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
            chk("late_data_held", 32'(data_o), 32'h20);
        end
        wait_ack(0, 1'b0, "late_ackfall", n);
        chk("late_data_held_done", 32'(data_o), 32'h20);
        wait_req_o(1'b1, "late_req1", n);
        chk("late_idle_gap", 32'(n), 32'd1);
        chk("late_grant", 32'(grant_o), 32'h2);
        chk("late_data", 32'(data_o), 32'h21);
        wait_ack(1, 1'b1, "late_ack1", n);
        wait_ack(1, 1'b0, "late_ackfall1", n);

        // Asynchronous reset while in REQ.
        do_reset();
        data_i[0 +: 8] = 8'h55;
        req_i[0] = 1'b1;
        wait_req_o(1'b1, "mid_req", n);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req_o", 32'(req_o), 32'd0);
        chk("mid_rst_ack_o", 32'(ack_o), 32'd0);
        chk("mid_rst_grant", 32'(grant_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        req_i = '0;
        dly   = '0;
        ack_i = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_req_o", 32'(req_o), 32'd0);

        // Stale ack held high in IDLE blocks the grant.
        do_reset();
        ds_auto = 1'b0;
        ack_i   = 1'b1;
        repeat (3) tick();
        data_i[0 +: 8] = 8'h77;
        req_i[0] = 1'b1;
        repeat (10) tick();
        chk("stale_no_req", 32'(req_o), 32'd0);
        chk("stale_no_busy", 32'(busy_o), 32'd0);
        ack_i = 1'b0;
        wait_req_o(1'b1, "stale_req", n);
        chk("stale_latency", 32'(n), 32'd3);
        chk("stale_data", 32'(data_o), 32'h77);
        ds_auto = 1'b1;
        wait_ack(0, 1'b1, "stale_ack", n);
        wait_ack(0, 1'b0, "stale_ackfall", n);

        // Randomized traffic against the round-robin reference.
        do_reset();
        ptr_m      = 0;
        n_grants   = 0;
        prev_req_o = req_o;
        mdl_on     = 1'b1;
        rnd_on     = 1'b1;
        repeat (3000) tick();
        rnd_on = 1'b0;
        n = 0;
        while ((req_i != 4'd0 || busy_o || ack_i) && n < 1000) begin
            tick();
            n++;
        end
        chk("rnd_drained", 32'((req_i == 4'd0) && !busy_o && !ack_i), 32'd1);
        chk("rnd_enough_grants", 32'(n_grants >= 20), 32'd1);
        mdl_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sync_merge_n.md
# sync_merge_n

Parametrised N-channel synchronising merge: each of N_CH asynchronous four-phase bundled-data requesters is synchronised into the `clk` domain. A round-robin arbiter grants one requester at a time and forwards its data word over a single four-phase output channel. The block is the clocked successor of the two-input merge: it generalises channel count, data width and synchroniser depth, and adds fair arbitration and a data path. It sits between asynchronous producers and one clocked or asynchronous consumer.

## Interface
Parameters:
- `N_CH`, 4, number of input channels (2..16)
- `DW`, 8, data width per channel (≥1)
- `SYNC_STAGES`, 2, flops per synchroniser (2..4)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `req_i`  in  N_CH  per-channel four-phase request, asynchronous to `clk`
- `data_i`  in  N_CH*DW  channel k at bits [k*DW +: DW]; stable from `req_i[k]` rise until `ack_o[k]` fall
- `ack_o`  out  N_CH  per-channel acknowledge, registered
- `req_o`  out  1  output request, registered
- `data_o`  out  DW  granted data, registered, valid while `req_o`=1
- `ack_i`  in  1  output acknowledge, asynchronous to `clk`
- `grant_o`  out  N_CH  one-hot current grant (all-zero in IDLE), registered
- `busy_o`  out  1  high in any state except IDLE

## Operation
- Synchronisers: every `req_i[k]` and `ack_i` passes through a `SYNC_STAGES` flop chain. `req_s` and `ack_s` denote the synchronised values. All decisions use only `req_s`/`ack_s`.
- Round-robin pointer `ptr` (width ceil(log2 N_CH), reset 0). Winner = first k with `req_s[k]`=1 scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (wrap modulo N_CH).
- FSM states, reset IDLE:
  - IDLE: if any `req_s` and `ack_s`=0 → latch winner w, `data_o` ← data_i[w], `grant_o` ← onehot(w), `req_o` ← 1, go REQ. Otherwise stay.
  - REQ: hold `req_o`=1 and `data_o`. When `ack_s`=1 → `req_o` ← 0, `ack_o[w]` ← 1, go ACK.
  - ACK: when `req_s[w]`=0 and `ack_s`=0 → `ack_o[w]` ← 0, `grant_o` ← 0, `ptr` ← (w+1) mod N_CH, go IDLE.
- At most one `ack_o` bit is high at any time. `ack_o` bits are never high outside ACK.
- A request arriving on another channel during a transaction waits. It is considered only in IDLE.
- Protocol violation: `req_s[w]` falling while in REQ is ignored. The transaction completes on the output side, and ACK then finishes on the first cycle both conditions hold.
- `ack_s`=1 seen in IDLE is treated as a stale ack: no grant is issued until it returns to 0.

## Timing
- Reset values: `ack_o`=0, `req_o`=0, `data_o`=0, `grant_o`=0, `busy_o`=0, `ptr`=0, all synchroniser flops 0, state IDLE.
- Reset is asynchronous on assertion. `reset_n` is synchronously deasserted externally. A reset mid-transaction drops `req_o`/`ack_o` immediately. Upstream and downstream must also be reset.
- Request latency: if `req_i[k]` is high before edge E0, `req_s[k]`=1 after edge E0+SYNC_STAGES-1, and `req_o`=1 after edge E0+SYNC_STAGES.
- Ack latency: same pattern. `ack_i` rise to `ack_o[w]` rise takes SYNC_STAGES+1 edges.
- Minimum IDLE dwell between transactions is 1 cycle (arbitration cycle).
- `data_o` changes only in the IDLE→REQ transition. It is held through REQ and ACK.
- `busy_o` is registered. It is high from the edge that sets `req_o` until the edge that clears `ack_o`.

## Structure
- Package `sync_merge_pkg`:
  - state enum `{IDLE, REQ, ACK}`
  - function `rr_pick(req, ptr)` returning a one-hot winner, parametrised via N_CH
- Sub-module `sync_nstage` (params `W`, `STAGES`; ports `clk`, `reset_n`, `d`, `q`). Instantiated once for `req_i` (W=N_CH) and once for `ack_i` (W=1).
- Top `sync_merge_n` holds the FSM, pointer, data mux and output registers.

## Test plan
Setup: N_CH=4, DW=8, SYNC_STAGES=2. Downstream model echoes `ack_i` = `req_o` delayed 120 ns. Clock period 10 ns.

- Single channel: `req_i[2]`=1 with `data_i[2]`=8'hA5 → `req_o` rises 3 edges later with `data_o`=8'hA5 and `grant_o`=4'b0100. `ack_o[2]` rises after `ack_i`. After `req_i[2]` falls, `ack_o[2]` falls and `ptr` becomes 3.
- Simultaneous requests: `req_i`=4'b1111 with data 8'h10/11/12/13, each requester dropping after its ack → grants in order ch0, 1, 2, 3. `data_o` sequence is 8'h10, 11, 12, 13. Never two `ack_o` bits high.
- Wrap-around: `ptr`=3 with `req_i`=4'b1001 → ch3 granted first, then ch0.
- Late arrival: `req_i[1]` rises while ch0 is in REQ → ch1 is granted only after ch0's ACK completes and one IDLE cycle passes. `data_o` stays on ch0's value until then.
- Reset mid-operation: `reset_n`=0 in REQ → same cycle `req_o`=0, `ack_o`=0, `grant_o`=0, `busy_o`=0. After release with `req_i`=0, the block stays in IDLE.
- Stale ack: `ack_i` held 1 while `req_i[0]`=1 in IDLE → no `req_o`. When `ack_i` falls, `req_o` rises SYNC_STAGES+1 edges later.
